// File: rtl/uart_mul_engine.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mul_engine
//  Brief    : Receives two operand bytes (A then B) over an AXI-Stream style
//             byte interface, multiplies them with an 8-step shift-add
//             datapath and returns the 16-bit product high byte first.
//  Options  : UART_MUL_TIMEOUT_EN - abandon a lone A byte after
//             TIMEOUT_CYCLES cycles in WAIT_B and pulse timeout_o.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_mul_engine #(
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       busy_o,
   output logic       timeout_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_B  = 3'd1,
      MUL     = 3'd2,
      SEND_HI = 3'd3,
      SEND_LO = 3'd4
   } state_t;

   localparam logic [3:0] c_MUL_STEPS = 4'd8;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_ready_en;
   logic [15:0] r_acc;
   logic [15:0] r_mcand;
   logic [7:0]  r_mplier;
   logic [3:0]  r_step;
   logic        w_s_xfer;
   logic        w_m_xfer;
   logic        w_timeout;

   // Reject an out-of-range timeout at elaboration.
   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 1048575)) begin : g_bad_timeout_cycles
      $error("uart_mul_engine: TIMEOUT_CYCLES out of range 2..2^20-1");
   end

   // Input side only accepts bytes while collecting operands; r_ready_en keeps
   // tready low during reset and until the first edge after release.
   assign s_axis_tready = r_ready_en && ((r_state == IDLE) || (r_state == WAIT_B));
   assign m_axis_tvalid = (r_state == SEND_HI) || (r_state == SEND_LO);
   assign m_axis_tdata  = (r_state == SEND_HI) ? r_acc[15:8] :
                          (r_state == SEND_LO) ? r_acc[7:0]  : 8'h00;
   assign busy_o        = (r_state != IDLE);
   assign timeout_o     = w_timeout;
   assign w_s_xfer      = s_axis_tvalid && s_axis_tready;
   assign w_m_xfer      = m_axis_tvalid && m_axis_tready;

`ifdef UART_MUL_TIMEOUT_EN
   localparam logic [19:0] c_TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

   logic [19:0] r_wait_cnt;

   // Cycle counter for WAIT_B, restarted whenever operand A is accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wait_cnt <= '0;
      end else if ((r_state == IDLE) && w_s_xfer) begin
         r_wait_cnt <= '0;
      end else if (r_state == WAIT_B) begin
         r_wait_cnt <= r_wait_cnt + 20'd1;
      end
   end

   // A B byte arriving on the expiry edge wins, so the timeout is masked by it.
   assign w_timeout = (r_state == WAIT_B) && !w_s_xfer && (r_wait_cnt == c_TIMEOUT_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   // Arm the input handshake one edge after reset release.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_ready_en <= 1'b0;
      else         r_ready_en <= 1'b1;
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_s_xfer) w_state_nxt = WAIT_B;
         WAIT_B: begin
            if (w_s_xfer)       w_state_nxt = MUL;
            else if (w_timeout) w_state_nxt = IDLE;
         end
         // Eight add steps, then one cycle with r_step == 8 before presenting.
         MUL:     if (r_step == c_MUL_STEPS) w_state_nxt = SEND_HI;
         SEND_HI: if (w_m_xfer) w_state_nxt = SEND_LO;
         SEND_LO: if (w_m_xfer) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture and shift-add multiplier: one multiplier bit per cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_step   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_s_xfer) r_mcand <= {8'h00, s_axis_tdata};
            end
            WAIT_B: begin
               if (w_s_xfer) begin
                  r_mplier <= s_axis_tdata;
                  r_acc    <= '0;
                  r_step   <= '0;
               end
            end
            MUL: begin
               if (r_step != c_MUL_STEPS) begin
                  if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                  r_mcand  <= {r_mcand[14:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[7:1]};
                  r_step   <= r_step + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_mul_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mul_engine
//  Brief    : Directed self-checking bench for uart_mul_engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mul_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] s_tdata = 8'h00;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tready = 1'b0;
   logic       busy;
   logic       timeout;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_mul_engine #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .busy_o        (busy),
      .timeout_o     (timeout)
   );

   // Offer one byte; returns at #1 after the transfer edge.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 1'b0;
      s_tdata  = b;
      s_tvalid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (s_tready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
   endtask

   // Accept one product byte; returns at #1 after the transfer edge.
   task automatic recv_byte(output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b  = 8'h00;
      m_tready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (m_tvalid) begin
            b = m_tdata;
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      m_tready = 1'b0;
   endtask

   // Edges until m_tvalid rises (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      while (!m_tvalid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
      tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
      tests++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL reset_m_tdata got=%h exp=00", m_tdata); end
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests++; if (timeout !== 1'b0)  begin fails++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL release_s_tready_before_edge got=%b exp=0", s_tready); end
      @(posedge clk); #1;
      tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL release_s_tready_after_edge got=%b exp=1", s_tready); end
   endtask

   task automatic test_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] hi, input logic [7:0] lo);
      bit ok1, ok2, ok3, ok4;
      int n;
      logic [7:0] got_hi, got_lo;
      send_byte(a, ok1);
      send_byte(b, ok2);
      tests++; if (s_tready !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL mul_%h_%h_in_mul tready=%b busy=%b exp tready=0 busy=1", a, b, s_tready, busy);
      end
      wait_valid(n);
      tests++; if (n != 9) begin fails++; $display("FAIL mul_%h_%h_latency got=%0d exp=9", a, b, n); end
      tests++; if (m_tdata !== hi) begin fails++; $display("FAIL mul_%h_%h_first_tdata got=%h exp=%h", a, b, m_tdata, hi); end
      recv_byte(got_hi, ok3);
      recv_byte(got_lo, ok4);
      tests++; if (!(ok1 && ok2 && ok3 && ok4)) begin
         fails++; $display("FAIL mul_%h_%h_handshake got=%b%b%b%b exp=1111", a, b, ok1, ok2, ok3, ok4);
      end
      tests++; if (got_hi !== hi) begin fails++; $display("FAIL mul_%h_%h_hi got=%h exp=%h", a, b, got_hi, hi); end
      tests++; if (got_lo !== lo) begin fails++; $display("FAIL mul_%h_%h_lo got=%h exp=%h", a, b, got_lo, lo); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mul_%h_%h_idle_busy got=%b exp=0", a, b, busy); end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, ok3, ok4;
      int n;
      int bad;
      logic [7:0] got_hi, got_lo;
      send_byte(8'hFF, ok1);
      send_byte(8'hFF, ok2);
      wait_valid(n);
      bad = 0;
      repeat (100) begin
         if (m_tdata !== 8'hFE || m_tvalid !== 1'b1 || s_tready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL backpressure_hold bad_cycles=%0d exp=0", bad); end
      recv_byte(got_hi, ok3);
      recv_byte(got_lo, ok4);
      tests++; if (!(ok1 && ok2 && ok3 && ok4)) begin
         fails++; $display("FAIL backpressure_handshake got=%b%b%b%b exp=1111", ok1, ok2, ok3, ok4);
      end
      tests++; if (got_hi !== 8'hFE) begin fails++; $display("FAIL backpressure_hi got=%h exp=fe", got_hi); end
      tests++; if (got_lo !== 8'h01) begin fails++; $display("FAIL backpressure_lo got=%h exp=01", got_lo); end
   endtask

   task automatic test_timeout();
      bit ok1;
      int pulses;
      send_byte(8'h12, ok1);
      pulses = 0;
      repeat (20) begin
         if (timeout === 1'b1) pulses++;
         @(posedge clk); #1;
      end
`ifdef UART_MUL_TIMEOUT_EN
      tests++; if (pulses != 1) begin fails++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got=%b exp=0", busy); end
      test_mul(8'h02, 8'h03, 8'h00, 8'h06);
`else
      begin
         bit ok2, ok3, ok4;
         int n;
         logic [7:0] got_hi, got_lo;
         tests++; if (pulses != 0) begin fails++; $display("FAIL no_timeout_pulses got=%0d exp=0", pulses); end
         tests++; if (busy !== 1'b1) begin fails++; $display("FAIL no_timeout_busy got=%b exp=1", busy); end
         send_byte(8'h03, ok2);
         wait_valid(n);
         tests++; if (n != 9) begin fails++; $display("FAIL no_timeout_latency got=%0d exp=9", n); end
         recv_byte(got_hi, ok3);
         recv_byte(got_lo, ok4);
         tests++; if (!(ok1 && ok2 && ok3 && ok4) || got_hi !== 8'h00 || got_lo !== 8'h36) begin
            fails++; $display("FAIL no_timeout_product got=%h%h ok=%b%b%b%b exp=0036 ok=1111",
                              got_hi, got_lo, ok1, ok2, ok3, ok4);
         end
      end
`endif
   endtask

   task automatic test_reset_mid_mul();
      bit ok1, ok2;
      int seen;
      send_byte(8'h10, ok1);
      send_byte(8'h10, ok2);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
         fails++; $display("FAIL midmul_reset_async busy=%b m_tvalid=%b s_tready=%b exp=000", busy, m_tvalid, s_tready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_tready = 1'b1;
      seen = 0;
      repeat (20) begin
         if (m_tvalid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      m_tready = 1'b0;
      tests++; if (!(ok1 && ok2) || seen != 0) begin
         fails++; $display("FAIL midmul_no_output valid_cycles=%0d ok=%b%b exp=0 ok=11", seen, ok1, ok2);
      end
      test_mul(8'h04, 8'h04, 8'h00, 8'h10);
   endtask

   task automatic test_back_to_back();
      logic [7:0] ins [6] = '{8'h07, 8'h09, 8'h80, 8'h02, 8'hC8, 8'h64};
      logic [7:0] exp [6] = '{8'h00, 8'h3F, 8'h01, 8'h00, 8'h4E, 8'h20};
      logic [7:0] got [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      int    ng;
      string seq;
      ng  = 0;
      seq = "";
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               s_tdata  = ins[i];
               s_tvalid = 1'b1;
               for (int c = 0; c < 100; c++) begin
                  if (s_tready) begin
                     @(posedge clk); #1;
                     break;
                  end
                  @(posedge clk); #1;
               end
            end
            s_tvalid = 1'b0;
         end
         begin
            m_tready = 1'b1;
            repeat (120) begin
               @(negedge clk);
               if (s_tvalid && s_tready) seq = {seq, "S"};
               if (m_tvalid && m_tready) begin
                  if (ng < 6) got[ng] = m_tdata;
                  ng++;
                  seq = {seq, "M"};
               end
            end
            m_tready = 1'b0;
         end
      join
      @(posedge clk); #1;
      tests++; if (seq != "SSMMSSMMSSMM") begin fails++; $display("FAIL b2b_order got=%s exp=SSMMSSMMSSMM", seq); end
      tests++; if (ng != 6) begin fails++; $display("FAIL b2b_count got=%0d exp=6", ng); end
      for (int i = 0; i < 6; i++) begin
         tests++; if (got[i] !== exp[i]) begin fails++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got[i], exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_mul(8'h03, 8'h05, 8'h00, 8'h0F);
      test_mul(8'hFF, 8'hFF, 8'hFE, 8'h01);
      test_mul(8'h00, 8'hAB, 8'h00, 8'h00);
      test_backpressure();
      test_timeout();
      test_reset_mid_mul();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_mul_engine.md
UART_MUL_ENGINE -- requirements
Module: uart_mul_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 120000, WAIT_B cycles allowed before the operand pair is abandoned; legal range 2..2^20-1.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port s_axis_tdata  input  8  operand byte from UART receiver.
REQ-005 SHALL have port s_axis_tvalid  input  1  operand byte valid.
REQ-006 SHALL have port s_axis_tready  output  1  engine accepts operand byte.
REQ-007 SHALL have port m_axis_tdata  output  8  product byte to UART transmitter.
REQ-008 SHALL have port m_axis_tvalid  output  1  product byte valid.
REQ-009 SHALL have port m_axis_tready  input  1  transmitter accepts product byte.
REQ-010 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-011 SHALL have port timeout_o  output  1  one-cycle pulse when a pair is abandoned.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_B, MUL, SEND_HI, SEND_LO.
REQ-013 SHALL transfer a byte on a rising edge with tvalid and tready both high; no other edge transfers data.
REQ-014 SHALL drive s_axis_tready high only in IDLE and WAIT_B; low in MUL, SEND_HI, SEND_LO.
REQ-015 SHALL, in IDLE, latch operand A on transfer and move to WAIT_B.
REQ-016 SHALL, in WAIT_B, latch operand B on transfer, clear the 16-bit accumulator, and move to MUL.
REQ-017 SHALL, in MUL, compute the unsigned 8x8 product with one shift-add step per cycle for exactly 8 cycles, then move to SEND_HI.
REQ-018 SHALL produce the full 16-bit product A*B with no truncation or saturation.
REQ-019 SHALL assert m_axis_tvalid in the cycle after the 8th MUL cycle, 9 edges after the B transfer edge.
REQ-020 SHALL, in SEND_HI, drive product[15:8]; on transfer move to SEND_LO.
REQ-021 SHALL, in SEND_LO, drive product[7:0]; on transfer move to IDLE.
REQ-022 SHALL hold m_axis_tvalid and m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 SHALL drive m_axis_tvalid low in IDLE, WAIT_B and MUL.
REQ-024 SHALL accept no new operand byte in the same edge as the SEND_LO transfer; the next A is accepted from the following cycle.
REQ-025 SHALL ignore s_axis_tdata while s_axis_tready is low; the upstream byte stays pending.

Reset
REQ-026 SHALL, with rst_ni low, immediately force state IDLE and s_axis_tready=0.
REQ-027 SHALL, with rst_ni low, immediately force m_axis_tvalid=0, m_axis_tdata=0x00, busy_o=0 and timeout_o=0.
REQ-028 SHALL, with rst_ni low, immediately clear the operand registers, the accumulator and the timeout counter.
REQ-029 SHALL drive s_axis_tready=1 from the first edge after rst_ni rises.
REQ-030 SHALL, on reset during MUL or SEND_*, discard the operation; no partial product byte is emitted after release.

Configuration
REQ-031 SHALL use the macro UART_MUL_TIMEOUT_EN.
REQ-032 SHALL, with UART_MUL_TIMEOUT_EN defined, count cycles in WAIT_B from 0, with the counter cleared on entry to WAIT_B.
REQ-033 SHALL, with UART_MUL_TIMEOUT_EN defined, return to IDLE and pulse timeout_o for one cycle when the count reaches TIMEOUT_CYCLES-1 with no transfer.
REQ-034 SHALL, with UART_MUL_TIMEOUT_EN defined, give a B transfer priority over a timeout occurring on the same edge.
REQ-035 SHALL, with UART_MUL_TIMEOUT_EN undefined, wait indefinitely in WAIT_B, tie timeout_o to 0 and omit the counter logic.

Verification
REQ-036 SHALL cover: send 0x03, 0x05 -> m_axis bytes 0x00 then 0x0F; m_axis_tvalid high 9 edges after the 0x05 transfer.
REQ-037 SHALL cover: send 0xFF, 0xFF -> bytes 0xFE then 0x01; send 0x00, 0xAB -> bytes 0x00 then 0x00.
REQ-038 SHALL cover: m_axis_tready held low 100 cycles in SEND_HI -> tdata 0xFE stable, s_axis_tready 0 throughout, then 0x01 follows.
REQ-039 SHALL cover: with UART_MUL_TIMEOUT_EN and TIMEOUT_CYCLES=16, send only 0x12, wait 20 cycles -> timeout_o pulses once, busy_o 0; then 0x02, 0x03 -> bytes 0x00 then 0x06.
REQ-040 SHALL cover: rst_ni pulsed low during the 4th MUL cycle of 0x10*0x10 -> no output byte; then 0x04, 0x04 -> bytes 0x00 then 0x10.
REQ-041 SHALL cover: back-to-back pairs with s_axis_tvalid held high -> each pair's two result bytes appear before the next A is accepted.
